// File: rtl/memstage_byte_seq.sv
// -----------------------------------------------------------------------------
// memstage_byte_seq
//
// Memory stage that turns one RV32I load/store request into a sequence of
// byte accesses on a byte-wide single-port RAM, then returns a single
// completion pulse. Loads are reassembled little-endian and sign/zero
// extended. Misaligned or illegal requests complete immediately with an error
// and never touch the RAM.
//
// Ports
//   clk, rst_n                 clock; synchronous active-low reset
//   req_valid / req_ready      request handshake (ready only in IDLE)
//   req_we, req_funct3         1 = store; RV32I width code
//   req_addr, req_wdata        byte address (low ADDR_W bits used); store data
//   rsp_valid                  one-cycle completion pulse
//   rsp_rdata, rsp_err         load result (0 for stores/errors); error flag
//   busy                       high in every state except IDLE
//   mem_ena, mem_wea           RAM enable / write enable
//   mem_addra, mem_dina        RAM byte address / write byte
//   mem_douta                  RAM read byte, valid one cycle after issue
// -----------------------------------------------------------------------------
module memstage_byte_seq #(
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic              mem_ena,
  output logic              mem_wea,
  output logic [ADDR_W-1:0] mem_addra,
  output logic [7:0]        mem_dina,
  input  logic [7:0]        mem_douta
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state, state_nxt;
  logic [1:0]        cnt, cnt_nxt;

  logic              we_q;
  logic [2:0]        funct3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       result_q;
  logic              err_q;

  logic              accept;
  logic              req_err;
  logic [1:0]        last_idx;
  logic [1:0]        prev_idx;

  // Address bits above the RAM window are intentionally ignored.
  logic              unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:ADDR_W];

  assign accept   = req_valid && (state == IDLE);
  // Index of the final byte: funct3[1:0] = 00 -> 0, 01 -> 1, 10 -> 3.
  assign last_idx = funct3_q[1] ? 2'd3 : {1'b0, funct3_q[0]};
  assign prev_idx = cnt - 2'd1;

  // Legality of the incoming request (alignment and width code).
  always_comb begin
    case (req_funct3)
      3'b000:  req_err = 1'b0;
      3'b001:  req_err = req_addr[0];
      3'b010:  req_err = |req_addr[1:0];
      3'b100:  req_err = req_we;
      3'b101:  req_err = req_we | req_addr[0];
      default: req_err = 1'b1;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, exactly like the hardware does.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 2'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path through it can leave a signal unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    req_ready = 1'b0;
    busy      = 1'b1;
    rsp_valid = 1'b0;
    mem_ena   = 1'b0;
    mem_wea   = 1'b0;
    mem_addra = '0;
    mem_dina  = 8'h00;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (accept) begin
          state_nxt = req_err ? RESP : ISSUE;
          cnt_nxt   = 2'd0;
        end
      end
      ISSUE: begin
        // RAM controls come only from captured registers and the counter.
        mem_ena   = 1'b1;
        mem_wea   = we_q;
        mem_addra = addr_q + ADDR_W'(cnt);
        mem_dina  = wdata_q[{cnt, 3'b000} +: 8];
        if (cnt == last_idx) begin
          cnt_nxt   = 2'd0;
          state_nxt = we_q ? RESP : WAIT;
        end else begin
          cnt_nxt   = cnt + 2'd1;
        end
      end
      WAIT: state_nxt = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: the request/result registers carry no reset; each is loaded on
  // acceptance before any state-qualified output can observe it.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q     <= req_we;
      funct3_q <= req_funct3;
      addr_q   <= req_addr[ADDR_W-1:0];
      wdata_q  <= req_wdata;
      err_q    <= req_err;
      result_q <= 32'h0;
    end
    // Read data lags the issue by one cycle: while issuing byte k we capture
    // byte k-1, and the WAIT cycle catches the final byte.
    if (state == ISSUE && !we_q && cnt != 2'd0) begin
      result_q[{prev_idx, 3'b000} +: 8] <= mem_douta;
    end
    if (state == WAIT) begin
      result_q[{last_idx, 3'b000} +: 8] <= mem_douta;
    end
  end

  assign rsp_err = (state == RESP) && err_q;

  always_comb begin
    rsp_rdata = 32'h0;
    if (state == RESP && !err_q && !we_q) begin
      case (funct3_q)
        3'b000:  rsp_rdata = {{24{result_q[7]}}, result_q[7:0]};
        3'b001:  rsp_rdata = {{16{result_q[15]}}, result_q[15:0]};
        3'b100:  rsp_rdata = {24'h0, result_q[7:0]};
        3'b101:  rsp_rdata = {16'h0, result_q[15:0]};
        default: rsp_rdata = result_q;
      endcase
    end
  end

endmodule
